// File: rtl/stream_compare_multi.sv
// Multi-lane A/B stream comparator. Each lane has a skew FIFO per side, a masked word
// compare, saturating statistics, and a latched snapshot of those statistics.
module stream_compare_multi #(
  parameter int TDATA_WIDTH = 32,
  parameter int N_LANES     = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_LANES*TDATA_WIDTH-1:0] S_AXIS_A_TDATA,
  input  logic [N_LANES-1:0]             S_AXIS_A_TVALID,
  output logic [N_LANES-1:0]             S_AXIS_A_TREADY,
  input  logic [N_LANES*TDATA_WIDTH-1:0] S_AXIS_B_TDATA,
  input  logic [N_LANES-1:0]             S_AXIS_B_TVALID,
  output logic [N_LANES-1:0]             S_AXIS_B_TREADY,
  input  logic [TDATA_WIDTH-1:0]         cmp_mask,
  input  logic                           clear,
  input  logic                           latch,
  output logic [N_LANES*CNT_WIDTH-1:0]   word_count,
  output logic [N_LANES*CNT_WIDTH-1:0]   err_count,
  output logic [N_LANES*CNT_WIDTH-1:0]   first_err_index,
  output logic [N_LANES-1:0]             first_err_valid,
  output logic [N_LANES-1:0]             skew_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [AW:0]            ptr_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;
  typedef logic [TDATA_WIDTH-1:0] word_t;

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    // Side index 0 is A, 1 is B.
    word_t      mem_q [2][FIFO_DEPTH];
    ptr_t       wp_q [2];
    ptr_t       wp_d [2];
    ptr_t       rp_q [2];
    ptr_t       rp_d [2];
    word_t      in_data [2];
    word_t      head [2];
    logic [1:0] in_valid;
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic       pop;
    logic       mismatch;

    cnt_t wc_q, wc_d, wc_upd;
    cnt_t ec_q, ec_d, ec_upd;
    cnt_t fei_q, fei_d, fei_upd;
    logic fev_q, fev_d, fev_upd;
    logic skew_q, skew_d, skew_upd;

    cnt_t owc_q, owc_d;
    cnt_t oec_q, oec_d;
    cnt_t ofei_q, ofei_d;
    logic ofev_q, ofev_d;
    logic oskew_q, oskew_d;

    assign in_valid   = {S_AXIS_B_TVALID[l], S_AXIS_A_TVALID[l]};
    assign in_data[0] = S_AXIS_A_TDATA[l*TDATA_WIDTH +: TDATA_WIDTH];
    assign in_data[1] = S_AXIS_B_TDATA[l*TDATA_WIDTH +: TDATA_WIDTH];

    always_comb begin
      for (int unsigned s = 0; s < 2; s++) begin
        empty[s] = (wp_q[s] == rp_q[s]);
        full[s]  = (wp_q[s][AW] != rp_q[s][AW]) &&
                   (wp_q[s][AW-1:0] == rp_q[s][AW-1:0]);
        push[s]  = in_valid[s] && !full[s];
        head[s]  = mem_q[s][rp_q[s][AW-1:0]];
      end
      pop      = !empty[0] && !empty[1];
      mismatch = |((head[0] ^ head[1]) & cmp_mask);
      for (int unsigned s = 0; s < 2; s++) begin
        wp_d[s] = clear ? '0 : wp_q[s] + ptr_t'(push[s]);
        rp_d[s] = clear ? '0 : rp_q[s] + ptr_t'(pop);
      end
    end

    // *_upd is the live state including this edge's pair; latch samples it before
    // clear is applied so a same-edge latch+clear captures the pre-clear totals.
    always_comb begin
      wc_upd   = wc_q;
      ec_upd   = ec_q;
      fei_upd  = fei_q;
      fev_upd  = fev_q;
      skew_upd = skew_q | (full[0] & empty[1]) | (full[1] & empty[0]);
      if (pop) begin
        if (wc_q != '1) wc_upd = wc_q + cnt_t'(1);
        if (mismatch) begin
          if (ec_q != '1) ec_upd = ec_q + cnt_t'(1);
          if (!fev_q) begin
            fei_upd = wc_q;
            fev_upd = 1'b1;
          end
        end
      end
      wc_d    = clear ? '0 : wc_upd;
      ec_d    = clear ? '0 : ec_upd;
      fei_d   = clear ? '0 : fei_upd;
      fev_d   = clear ? 1'b0 : fev_upd;
      skew_d  = clear ? 1'b0 : skew_upd;
      owc_d   = latch ? wc_upd   : owc_q;
      oec_d   = latch ? ec_upd   : oec_q;
      ofei_d  = latch ? fei_upd  : ofei_q;
      ofev_d  = latch ? fev_upd  : ofev_q;
      oskew_d = latch ? skew_upd : oskew_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned s = 0; s < 2; s++) begin
          wp_q[s] <= '0;
          rp_q[s] <= '0;
        end
        wc_q    <= '0;
        ec_q    <= '0;
        fei_q   <= '0;
        fev_q   <= 1'b0;
        skew_q  <= 1'b0;
        owc_q   <= '0;
        oec_q   <= '0;
        ofei_q  <= '0;
        ofev_q  <= 1'b0;
        oskew_q <= 1'b0;
      end else begin
        for (int unsigned s = 0; s < 2; s++) begin
          wp_q[s] <= wp_d[s];
          rp_q[s] <= rp_d[s];
        end
        wc_q    <= wc_d;
        ec_q    <= ec_d;
        fei_q   <= fei_d;
        fev_q   <= fev_d;
        skew_q  <= skew_d;
        owc_q   <= owc_d;
        oec_q   <= oec_d;
        ofei_q  <= ofei_d;
        ofev_q  <= ofev_d;
        oskew_q <= oskew_d;
      end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (push[s]) mem_q[s][wp_q[s][AW-1:0]] <= in_data[s];
      end
    end

    assign S_AXIS_A_TREADY[l] = !full[0];
    assign S_AXIS_B_TREADY[l] = !full[1];
    assign word_count[l*CNT_WIDTH +: CNT_WIDTH]      = owc_q;
    assign err_count[l*CNT_WIDTH +: CNT_WIDTH]       = oec_q;
    assign first_err_index[l*CNT_WIDTH +: CNT_WIDTH] = ofei_q;
    assign first_err_valid[l] = ofev_q;
    assign skew_err[l]        = oskew_q;
  end

endmodule

// File: doc/stream_compare_multi.md
STREAM_COMPARE_MULTI -- requirements
Module: stream_compare_multi

Interface
REQ-001 The module SHALL have parameter TDATA_WIDTH, default 32: width of each lane's data word.
REQ-002 The module SHALL have parameter N_LANES, default 2: number of independent A/B comparison lanes (1..16).
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 8: per-side skew FIFO depth in words (power of 2, >=2).
REQ-004 The module SHALL have parameter CNT_WIDTH, default 32: width of all counters.
REQ-005 The module SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 The module SHALL have ports S_AXIS_A_TDATA, input, N_LANES*TDATA_WIDTH, and S_AXIS_A_TVALID, input, N_LANES, carrying A-side data per lane (lane i at bits i*TDATA_WIDTH upward).
REQ-008 The module SHALL have port S_AXIS_A_TREADY, output, N_LANES: A-side ready per lane.
REQ-009 The module SHALL have ports S_AXIS_B_TDATA, S_AXIS_B_TVALID and S_AXIS_B_TREADY, mirroring REQ-007 and REQ-008 for the B side.
REQ-010 The module SHALL have port cmp_mask, input, TDATA_WIDTH: bits included in the comparison (1 = compared).
REQ-011 The module SHALL have port clear, input, 1: synchronous pulse that zeroes live statistics on all lanes.
REQ-012 The module SHALL have port latch, input, 1: synchronous pulse that snapshots live statistics into the output registers.
REQ-013 The module SHALL have ports word_count and err_count, output, N_LANES*CNT_WIDTH each: latched per-lane compared-pair count and mismatch count.
REQ-014 The module SHALL have port first_err_index, output, N_LANES*CNT_WIDTH: latched per-lane word index of the first mismatch.
REQ-015 The module SHALL have ports first_err_valid and skew_err, output, N_LANES each: latched per-lane first-mismatch-seen flag and sticky skew fault.

Function
REQ-016 Each lane SHALL contain one FIFO per side of FIFO_DEPTH words; TREADY SHALL be high if and only if that FIFO is not full (registered state only, no combinational path from TVALID).
REQ-017 A word SHALL be pushed on a clock edge where TVALID and TREADY are both high.
REQ-018 When both FIFOs of a lane are non-empty, the lane SHALL pop one word from each at that edge and compare them; a pushed word SHALL be poppable no earlier than the edge after its push.
REQ-019 A pair SHALL be a mismatch if and only if ((A xor B) and cmp_mask) is nonzero; cmp_mask all-zero SHALL yield no mismatches.
REQ-020 Each compared pair SHALL increment live word_count; each mismatch SHALL also increment live err_count; both SHALL saturate at all-ones and never wrap.
REQ-021 On the first mismatch since reset or clear, the lane SHALL record live first_err_index equal to the live word_count value before that pair's increment (0-based) and set live first_err_valid; later mismatches SHALL NOT change either value.
REQ-022 Live skew_err SHALL set, sticky, on any cycle where one FIFO of a lane is full while the other is empty.
REQ-023 A clear pulse SHALL zero all live counters, first_err_valid, first_err_index, skew_err and flush all FIFOs; any pair compared on that same edge SHALL be discarded.
REQ-024 A latch pulse SHALL copy every lane's live statistics to the outputs at that edge; outputs SHALL otherwise hold.
REQ-025 If latch and clear are asserted on the same edge, the outputs SHALL capture the pre-clear live values, which include any pair compared on that edge.
REQ-026 Lanes SHALL be fully independent: activity or backpressure on one lane SHALL NOT affect another.

Reset
REQ-027 While reset is high, all FIFOs SHALL be empty, all live and latched statistics SHALL be zero, and all TREADY outputs SHALL be high.
REQ-028 Reset assertion SHALL take effect immediately, including mid-transfer, with in-flight words discarded; normal operation SHALL resume on the first edge after deassertion.

Verification
REQ-029 Identical streams: 100 words per side on lane 0 with cmp_mask all-ones, then latch -> word_count=100, err_count=0, first_err_valid=0.
REQ-030 Mismatches: words 5 and 9 of 20 differ in bit 3, cmp_mask all-ones, then latch -> err_count=2, first_err_index=5, first_err_valid=1; repeat with cmp_mask bit 3 cleared -> err_count=0.
REQ-031 Skew: FIFO_DEPTH=8, A sends 8 words while B is idle -> A TREADY low after the 8th push and skew_err=1 after latch; B then sends 8 matching words -> word_count=8, err_count=0.
REQ-032 Saturation: CNT_WIDTH=4, 20 mismatching pairs, then latch -> word_count=15, err_count=15.
REQ-033 Latch and clear on the same edge after 10 compared pairs -> outputs show word_count=10; a second latch alone -> word_count=0.
REQ-034 Reset asserted with 3 words queued on lane 1 A -> all outputs 0 and TREADY high during reset; 3 matching pairs sent after release, then latch -> word_count=3.
